// File: rtl/instr_encoder_if.sv
// instr_encoder_if: command-in / IM-write-out bundle of the instruction encoder.
//   cmd_*    : symbolic instruction command with valid/ready handshake
//   flush    : pad the rest of IM with NOPs, then finish
//   restart  : leave DONE and begin a new program at index 0
//   im_*     : instruction memory write port (byte address, 32-bit word)
//   count    : words written so far; full / done / err : status
// master = command source (boot/test program), slave = encoder.
interface instr_encoder_if #(
  parameter int DEPTH_LOG2 = 10
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [3:0]            cmd_kind;
  logic [4:0]            cmd_rs;
  logic [4:0]            cmd_rt;
  logic [4:0]            cmd_rd;
  logic [15:0]           cmd_imm;
  logic [25:0]           cmd_target;
  logic                  flush;
  logic                  restart;
  logic                  im_we;
  logic [31:0]           im_addr;
  logic [31:0]           im_wdata;
  logic [DEPTH_LOG2:0]   count;
  logic                  full;
  logic                  done;
  logic                  err;

  modport master (
    output cmd_valid, cmd_kind, cmd_rs, cmd_rt, cmd_rd, cmd_imm, cmd_target,
           flush, restart,
    input  cmd_ready, im_we, im_addr, im_wdata, count, full, done, err
  );

  modport slave (
    input  cmd_valid, cmd_kind, cmd_rs, cmd_rt, cmd_rd, cmd_imm, cmd_target,
           flush, restart,
    output cmd_ready, im_we, im_addr, im_wdata, count, full, done, err
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs symbolic MIPS-subset commands into 32-bit machine words
// and writes them sequentially into instruction memory from BASE_ADDR upward.
// A flush pads the remaining words with NOPs (32'h0) and finishes.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous, active-high
//   bus   : instr_encoder_if.slave (command handshake, IM write port, status)
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_RUN   | accepting commands, one encoded word written per accept
// S_FLUSH | writing one NOP per cycle until the last IM word
// S_DONE  | IM image complete; waits for restart
module instr_encoder #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_3000
) (
  input  logic          clk,
  input  logic          reset,
  instr_encoder_if.slave bus
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [DEPTH_LOG2:0] IDX_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] IDX_LAST = {1'b0, {DEPTH_LOG2{1'b1}}};
  localparam logic [DEPTH_LOG2:0] IDX_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};

  localparam logic [3:0] K_ADDU = 4'd0;
  localparam logic [3:0] K_SUBU = 4'd1;
  localparam logic [3:0] K_JR   = 4'd2;
  localparam logic [3:0] K_LW   = 4'd3;
  localparam logic [3:0] K_SW   = 4'd4;
  localparam logic [3:0] K_BEQ  = 4'd5;
  localparam logic [3:0] K_LUI  = 4'd6;
  localparam logic [3:0] K_ORI  = 4'd7;
  localparam logic [3:0] K_JAL  = 4'd8;

  state_t              state_q, state_d;
  logic [DEPTH_LOG2:0] idx_q, idx_d;
  logic                we_q, we_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                err_q, err_d;

  logic                full;
  logic                ready;
  logic                accept;
  logic                legal;
  logic [31:0]         word_addr;
  logic [31:0]         enc_word;

  // Fields not used by a kind are ignored; LUI's rs and JR's rt/rd are
  // forced to zero so stray command bits never reach the decoder.
  function automatic logic [31:0] encode(
    input logic [3:0]  kind,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [31:0] w;
    w = 32'h0;
    case (kind)
      K_ADDU:  w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100000};
      K_SUBU:  w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100010};
      K_JR:    w = {6'b000000, rs, 5'b00000, 5'b00000, 5'b00000, 6'b001000};
      K_LW:    w = {6'b100011, rs, rt, imm};
      K_SW:    w = {6'b101011, rs, rt, imm};
      K_BEQ:   w = {6'b000100, rs, rt, imm};
      K_LUI:   w = {6'b001111, 5'b00000, rt, imm};
      K_ORI:   w = {6'b001101, rs, rt, imm};
      K_JAL:   w = {6'b000011, target};
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  assign full      = (idx_q == IDX_FULL);
  assign ready     = (state_q == S_RUN) & ~full & ~bus.flush & ~reset;
  assign accept    = bus.cmd_valid & ready;
  assign legal     = (bus.cmd_kind <= K_JAL);
  assign word_addr = BASE_ADDR + {{(29 - DEPTH_LOG2){1'b0}}, idx_q, 2'b00};
  assign enc_word  = encode(bus.cmd_kind, bus.cmd_rs, bus.cmd_rt, bus.cmd_rd,
                            bus.cmd_imm, bus.cmd_target);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    case (state_q)
      S_RUN: begin
        // full is checked first: the last write lands with idx reaching
        // full, and the next cycle finishes regardless of flush.
        if (full) begin
          state_d = S_DONE;
        end else if (bus.flush) begin
          state_d = S_FLUSH;
        end else if (accept) begin
          if (legal) begin
            we_d    = 1'b1;
            addr_d  = word_addr;
            wdata_d = enc_word;
            idx_d   = idx_q + IDX_ONE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_FLUSH: begin
        if (full) begin
          state_d = S_DONE;
        end else begin
          we_d    = 1'b1;
          addr_d  = word_addr;
          wdata_d = 32'h0;
          idx_d   = idx_q + IDX_ONE;
          if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (bus.restart) begin
          state_d = S_RUN;
          idx_d   = '0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RUN;
      idx_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= BASE_ADDR;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.cmd_ready = ready;
  assign bus.im_we     = we_q;
  assign bus.im_addr   = addr_q;
  assign bus.im_wdata  = wdata_q;
  assign bus.count     = idx_q;
  assign bus.full      = full;
  assign bus.done      = (state_q == S_DONE);
  assign bus.err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
  localparam logic [31:0] BASE = 32'h0000_3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst3, rst2;

  instr_encoder_if #(.DEPTH_LOG2(3)) b3();
  instr_encoder_if #(.DEPTH_LOG2(2)) b2();

  instr_encoder #(.DEPTH_LOG2(3), .BASE_ADDR(BASE)) u3 (
    .clk(clk), .reset(rst3), .bus(b3.slave)
  );
  instr_encoder #(.DEPTH_LOG2(2), .BASE_ADDR(BASE)) u2 (
    .clk(clk), .reset(rst2), .bus(b2.slave)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t act_q[$];
  wr_t exp_q[$];
  int  m_idx;   // model: next IM index of the 8-word instance
  bit  m_err;   // model: sticky illegal-kind flag

  typedef struct {
    logic [3:0]  kind;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] word;
  } vec_t;

  vec_t vecs[$];

  always @(negedge clk) begin
    if (b3.im_we === 1'b1) act_q.push_back({b3.im_addr, b3.im_wdata});
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference encoding from the field layout: op<<26 | rs<<21 | rt<<16 | rd<<11 | func
  function automatic logic [31:0] ref_enc(input logic [31:0] kind, input logic [31:0] rs,
                                          input logic [31:0] rt, input logic [31:0] rd,
                                          input logic [31:0] imm, input logic [31:0] tgt);
    logic [31:0] r, i;
    r = rs * 32'h0020_0000 + rt * 32'h0001_0000 + rd * 32'h0000_0800;
    i = rs * 32'h0020_0000 + rt * 32'h0001_0000 + imm;
    case (kind)
      0: return r + 32'd32;
      1: return r + 32'd34;
      2: return rs * 32'h0020_0000 + 32'd8;
      3: return 32'd35 * 32'h0400_0000 + i;
      4: return 32'd43 * 32'h0400_0000 + i;
      5: return 32'd4  * 32'h0400_0000 + i;
      6: return 32'd15 * 32'h0400_0000 + rt * 32'h0001_0000 + imm;
      7: return 32'd13 * 32'h0400_0000 + i;
      8: return 32'd3  * 32'h0400_0000 + tgt;
      default: return 32'h0;
    endcase
  endfunction

  task automatic cmp_writes();
    int n;
    chk("wr_count", act_q.size(), exp_q.size());
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk("wr_addr", act_q[i].addr, exp_q[i].addr);
      chk("wr_data", act_q[i].data, exp_q[i].data);
    end
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic idle3();
    b3.cmd_valid = 0; b3.cmd_kind = 0; b3.cmd_rs = 0; b3.cmd_rt = 0; b3.cmd_rd = 0;
    b3.cmd_imm = 0; b3.cmd_target = 0; b3.flush = 0; b3.restart = 0;
  endtask

  task automatic wait_done3(input int budget);
    int n = 0;
    while (b3.done !== 1'b1 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk("done_reached", b3.done, 1'b1);
  endtask

  task automatic restart3();
    wait_done3(20);
    b3.restart = 1;
    @(negedge clk);
    b3.restart = 0;
    #1;
    chk("restart_count", b3.count, 0);
    chk("restart_ready", b3.cmd_ready, 1'b1);
    chk("restart_err", b3.err, 1'b0);
    m_idx = 0;
    m_err = 0;
  endtask

  // Called at negedge+1; returns at negedge+1 after the accept edge.
  task automatic send3(input logic [3:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                       input logic [31:0] expw);
    int n = 0;
    if (m_idx == 8) restart3();
    while (b3.cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    chk("ready_before_send", b3.cmd_ready, 1'b1);
    b3.cmd_kind = kind; b3.cmd_rs = rs; b3.cmd_rt = rt; b3.cmd_rd = rd;
    b3.cmd_imm = imm; b3.cmd_target = tgt; b3.cmd_valid = 1;
    @(posedge clk);
    @(negedge clk);
    b3.cmd_valid = 0;
    #1;
    if (kind <= 8) begin
      exp_q.push_back({BASE + 32'(m_idx) * 4, expw});
      m_idx++;
    end else begin
      m_err = 1;
    end
    cmp_writes();
    chk("count", b3.count, m_idx);
    chk("err", b3.err, m_err);
  endtask

  task automatic flush3();
    if (m_idx == 8) restart3();
    b3.flush = 1;
    b3.cmd_valid = 1; b3.cmd_kind = 0; b3.cmd_rs = 1; b3.cmd_rt = 2; b3.cmd_rd = 3;
    @(posedge clk);
    @(negedge clk);
    b3.flush = 0;
    b3.cmd_valid = 0;
    #1;
    chk("flush_ready_low", b3.cmd_ready, 1'b0);
    wait_done3(20);
    for (int i = m_idx; i < 8; i++) exp_q.push_back({BASE + 32'(i) * 4, 32'h0});
    m_idx = 8;
    cmp_writes();
    chk("flush_count", b3.count, 8);
    chk("flush_full", b3.full, 1'b1);
    chk("flush_err_kept", b3.err, m_err);
  endtask

  initial begin
    int nw;
    logic [3:0]  k;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] tgt;

    idle3();
    b2.cmd_valid = 0; b2.cmd_kind = 0; b2.cmd_rs = 0; b2.cmd_rt = 0; b2.cmd_rd = 0;
    b2.cmd_imm = 0; b2.cmd_target = 0; b2.flush = 0; b2.restart = 0;
    rst3 = 1; rst2 = 1;
    m_idx = 0; m_err = 0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_ready", b3.cmd_ready, 1'b0);
    chk("rst_we", b3.im_we, 1'b0);
    chk("rst_addr", b3.im_addr, BASE);
    chk("rst_wdata", b3.im_wdata, 32'h0);
    chk("rst_err", b3.err, 1'b0);
    chk("rst_count", b3.count, 0);
    chk("rst_done", b3.done, 1'b0);
    rst3 = 0; rst2 = 0;
    #1;
    chk("ready_after_rst", b3.cmd_ready, 1'b1);

    // Back-to-back ADDU then ORI, one write per cycle
    b3.cmd_valid = 1; b3.cmd_kind = 0; b3.cmd_rs = 1; b3.cmd_rt = 2; b3.cmd_rd = 3;
    @(negedge clk);
    b3.cmd_kind = 7; b3.cmd_rs = 0; b3.cmd_rt = 2; b3.cmd_imm = 16'h1234;
    #1;
    chk("b2b_we0", b3.im_we, 1'b1);
    chk("b2b_addr0", b3.im_addr, 32'h0000_3000);
    chk("b2b_data0", b3.im_wdata, 32'h0022_1820);
    @(negedge clk);
    b3.cmd_valid = 0;
    #1;
    chk("b2b_we1", b3.im_we, 1'b1);
    chk("b2b_addr1", b3.im_addr, 32'h0000_3004);
    chk("b2b_data1", b3.im_wdata, 32'h3402_1234);
    chk("b2b_count", b3.count, 2);
    @(negedge clk); #1;
    chk("b2b_we_idle", b3.im_we, 1'b0);
    chk("b2b_addr_hold", b3.im_addr, 32'h0000_3004);
    act_q.delete();
    m_idx = 2;

    // Table of encodings; unused fields carry garbage that must be ignored
    vecs.push_back('{4'd0, 5'd1,  5'd2, 5'd3,  16'hFFFF, 26'h3FFFFFF, 32'h0022_1820});
    vecs.push_back('{4'd7, 5'd0,  5'd2, 5'd31, 16'h1234, 26'h1555555, 32'h3402_1234});
    vecs.push_back('{4'd6, 5'd7,  5'd1, 5'd31, 16'hABCD, 26'h2AAAAAA, 32'h3C01_ABCD});
    vecs.push_back('{4'd8, 5'd9,  5'd9, 5'd9,  16'h5555, 26'h0000C03, 32'h0C00_0C03});
    vecs.push_back('{4'd2, 5'd31, 5'd5, 5'd9,  16'h7777, 26'h1234567, 32'h03E0_0008});
    vecs.push_back('{4'd5, 5'd1,  5'd2, 5'd17, 16'hFFFF, 26'h0, 32'h1022_FFFF});
    vecs.push_back('{4'd3, 5'd5,  5'd4, 5'd1,  16'h0008, 26'h0, 32'h8CA4_0008});
    vecs.push_back('{4'd4, 5'd5,  5'd4, 5'd1,  16'h0008, 26'h0, 32'hACA4_0008});
    vecs.push_back('{4'd1, 5'd4,  5'd5, 5'd6,  16'hFFFF, 26'h0, 32'h0085_3022});
    vecs.push_back('{4'd0, 5'd1,  5'd2, 5'd3,  16'h0,    26'h0, 32'h0022_1820});
    vecs.push_back('{4'd12, 5'd1, 5'd2, 5'd3,  16'h0,    26'h0, 32'h0});
    vecs.push_back('{4'd7, 5'd0,  5'd2, 5'd0,  16'h1234, 26'h0, 32'h3402_1234});
    foreach (vecs[i])
      send3(vecs[i].kind, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].imm, vecs[i].tgt,
            vecs[i].word);

    // Illegal kind between two commands: second lands at 0x3004, err sticks
    if (m_idx != 8) flush3();
    restart3();
    send3(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h0022_1820);
    send3(4'd12, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h0);
    send3(4'd7, 5'd0, 5'd2, 5'd0, 16'h1234, 26'h0, 32'h3402_1234);
    chk("illegal_err_sticky", b3.err, 1'b1);

    // 3 commands then flush (with cmd_valid high): NOPs at 0x300C..0x301C
    flush3();
    restart3();
    for (int i = 0; i < 3; i++) send3(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h0022_1820);
    flush3();

    // Reset in the middle of a flush
    restart3();
    for (int i = 0; i < 3; i++) send3(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h0022_1820);
    b3.flush = 1;
    @(negedge clk);
    b3.flush = 0;
    @(negedge clk);
    @(negedge clk);
    #1;
    rst3 = 1;
    @(negedge clk); #1;
    chk("rst_flush_we", b3.im_we, 1'b0);
    chk("rst_flush_count", b3.count, 0);
    chk("rst_flush_ready", b3.cmd_ready, 1'b0);
    chk("rst_flush_done", b3.done, 1'b0);
    exp_q.push_back({32'h0000_300C, 32'h0});
    exp_q.push_back({32'h0000_3010, 32'h0});
    cmp_writes();
    rst3 = 0;
    m_idx = 0; m_err = 0;
    #1;
    chk("rst_flush_ready_after", b3.cmd_ready, 1'b1);

    // Randomized commands against the reference model
    for (int it = 0; it < 250; it++) begin
      int r;
      r = $urandom_range(0, 24);
      if (r == 0) begin
        flush3();
      end else begin
        k   = (r < 4) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
        rs  = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
        imm = 16'($urandom); tgt = 26'($urandom);
        send3(k, rs, rt, rd, imm, tgt, ref_enc(32'(k), 32'(rs), 32'(rt), 32'(rd),
                                               32'(imm), 32'(tgt)));
      end
    end

    // 4-word instance: commands held valid, exactly 4 writes then done
    b2.cmd_valid = 1; b2.cmd_kind = 0; b2.cmd_rs = 1; b2.cmd_rt = 2; b2.cmd_rd = 3;
    nw = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      if (b2.im_we === 1'b1) begin
        chk("d2_addr", b2.im_addr, BASE + 32'(nw) * 4);
        chk("d2_data", b2.im_wdata, 32'h0022_1820);
        nw++;
      end
    end
    chk("d2_writes", nw, 4);
    chk("d2_ready", b2.cmd_ready, 1'b0);
    chk("d2_full", b2.full, 1'b1);
    chk("d2_done", b2.done, 1'b1);
    b2.cmd_valid = 0;
    b2.restart = 1;
    @(negedge clk);
    b2.restart = 0;
    #1;
    chk("d2_restart_count", b2.count, 0);
    chk("d2_restart_ready", b2.cmd_ready, 1'b1);
    chk("d2_restart_done", b2.done, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Encoder for the team's MIPS instruction subset; the control decoder consumes exactly these words.
- Accepts symbolic instruction commands (kind + register/immediate/target fields) over a valid/ready handshake.
- Packs each command into a 32-bit machine word and writes it sequentially into instruction memory starting at the PC base.
- On request, pads the remaining memory with NOPs.
- Sits between the test/boot program source and the IM write port.

Parameters:
- DEPTH_LOG2, 10, log2 of IM depth in words.
- BASE_ADDR, 32'h00003000, byte address of IM word 0.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  encoder can accept a command this cycle.
- cmd_kind  input  4  0=ADDU 1=SUBU 2=JR 3=LW 4=SW 5=BEQ 6=LUI 7=ORI 8=JAL; 9-15 illegal.
- cmd_rs  input  5  rs field.
- cmd_rt  input  5  rt field.
- cmd_rd  input  5  rd field.
- cmd_imm  input  16  immediate or offset.
- cmd_target  input  26  JAL target field.
- flush  input  1  pad the rest of IM with NOPs, then finish.
- restart  input  1  in DONE: return to RUN with index 0.
- im_we  output  1  IM write enable.
- im_addr  output  32  IM byte address.
- im_wdata  output  32  IM write data.
- count  output  DEPTH_LOG2+1  words written so far (next index).
- full  output  1  count == 2^DEPTH_LOG2.
- done  output  1  state is DONE.
- err  output  1  sticky flag: illegal kind seen.

Behaviour:
- Reset, while reset is high and at the first edge after it:
  - state=RUN, idx=0.
  - im_we=0, im_addr=BASE_ADDR, im_wdata=0, err=0.
  - cmd_ready=0 while reset is high.
- Combinational outputs:
  - cmd_ready = (state==RUN) & ~full & ~flush & ~reset.
  - count = idx; full = (idx == 2^DEPTH_LOG2); done = (state==DONE).
- Encoding, R-type (op=000000, shamt=0):
  - ADDU: {0,rs,rt,rd,0,100000}.
  - SUBU: func 100010.
  - JR: {0,rs,5'b0,5'b0,0,001000}.
- Encoding, I-type {op,rs,rt,imm}:
  - LW op 100011; SW op 101011; BEQ op 000100; ORI op 001101.
  - LUI op 001111 with rs forced to 0.
- Encoding, J-type: JAL = {000011, target}.
- Unused cmd fields are ignored (forced to 0 where listed).
- RUN state:
  - Accept on cmd_valid & cmd_ready. Next cycle: im_we=1, im_addr=BASE_ADDR+4*idx, im_wdata=encoded word; idx increments.
  - Latency is exactly 1 cycle. Throughput is one word per cycle; back-to-back accepts are legal.
  - Illegal kind: accepted and consumed, no write (im_we=0), idx unchanged, err set and held.
  - When idx reaches 2^DEPTH_LOG2 (after the last write): go to DONE; cmd_ready already low.
  - flush high in RUN: flush beats cmd_valid (the command is not accepted); go to FLUSH.
  - flush high with full=1: go directly to DONE.
- FLUSH state:
  - Each cycle writes 32'h00000000 at BASE_ADDR+4*idx (im_we=1), then idx++.
  - Go to DONE after writing index 2^DEPTH_LOG2-1.
  - cmd_ready=0 throughout.
- DONE state:
  - im_we=0.
  - restart → RUN with idx=0 and err=0; restart is ignored in any other state.
- Outside writes, im_we=0; im_addr and im_wdata hold their last values.
- Reset mid-FLUSH or mid-RUN: im_we deasserts at that edge and the in-flight word is dropped.
- Address arithmetic is 32-bit; idx never wraps, because it saturates at 2^DEPTH_LOG2.

Test Plan:
- ADDU rs=1 rt=2 rd=3, then ORI rs=0 rt=2 imm=0x1234 → im_wdata=0x00221820 @0x00003000, then 0x34021234 @0x00003004, on consecutive cycles; count=2.
- LUI rs=7 rt=1 imm=0xABCD → 0x3C01ABCD (rs forced 0). JAL target=0x0000C03 → 0x0C000C03. JR rs=31 → 0x03E00008.
- BEQ rs=1 rt=2 imm=0xFFFF → 0x1022FFFF. LW rs=5 rt=4 imm=8 → 0x8CA40008. SW with the same fields → 0xACA40008.
- Kind=12 between two valid commands → err=1, no im_we pulse, second command lands at 0x00003004.
- DEPTH_LOG2=2, 5 commands held valid → 4 writes (0x3000..0x300C), then cmd_ready=0, full=1, done=1. Restart → count=0, cmd_ready=1.
- DEPTH_LOG2=3, 3 commands then flush (with cmd_valid also high) → the command is not accepted; NOPs written at 0x300C..0x301C over 5 cycles; done=1. Reset asserted during the flush → im_we=0 on the next edge, count=0.
